// File: rtl/dcache_pkg.sv
// -----------------------------------------------------------------------------
// dcache_pkg
// Shared types and width helpers for the N-way set-associative data cache.
//   state_t       : miss-handling FSM states
//   line_state_t  : per-line status bits (valid, dirty)
//   idx_width     : set-index width from the number of sets
//   tag_width     : tag width from address width and number of sets
//   plru_width    : tree pseudo-LRU bits per set (WAYS-1)
//   way_width     : width of a way number
// -----------------------------------------------------------------------------
package dcache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_REFILL    = 2'd2,
        ST_RESPOND   = 2'd3
    } state_t;

    // Status half of a cache line. Tag and data widths depend on the
    // parameters of each cache instance, so those fields live in separate
    // per-instance arrays indexed the same way as this struct.
    typedef struct packed {
        logic valid;
        logic dirty;
    } line_state_t;

    function automatic int idx_width(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_width(input int addr_w, input int sets);
        return addr_w - $clog2(sets);
    endfunction

    function automatic int plru_width(input int ways);
        return ways - 1;
    endfunction

    function automatic int way_width(input int ways);
        return $clog2(ways);
    endfunction

endpackage

// File: rtl/dcache_nway_plru_tree.sv
// -----------------------------------------------------------------------------
// plru_tree
// Tree pseudo-LRU helper for one cache set. Purely combinational.
// The tree is stored heap-ordered: node 0 is the root, children of node n are
// 2n+1 (lower half of the ways) and 2n+2 (upper half). A node bit of 0 steers
// the victim walk into the lower half, 1 into the upper half.
//   tree_bits  in  WAYS-1   current tree bits of the set
//   access_way in  log2WAYS way being touched (hit or fill)
//   victim_way out log2WAYS way the tree currently points at
//   tree_next  out WAYS-1   tree bits after touching access_way
// -----------------------------------------------------------------------------
module plru_tree #(
    parameter int WAYS = 2
) (
    input  logic [WAYS-2:0]         tree_bits,
    input  logic [$clog2(WAYS)-1:0] access_way,
    output logic [$clog2(WAYS)-1:0] victim_way,
    output logic [WAYS-2:0]         tree_next
);

    localparam int LEVELS = $clog2(WAYS);

    logic [LEVELS-1:0] node_v;
    logic [LEVELS-1:0] node_u;

    // Victim walk: follow the node bits from the root down.
    always_comb begin
        victim_way = '0;
        node_v     = '0;
        for (int lvl = 0; lvl < LEVELS; lvl++) begin
            victim_way[LEVELS-1-lvl] = tree_bits[node_v];
            node_v = LEVELS'((32'(node_v) << 1) + 32'd1 + 32'(tree_bits[node_v]));
        end
    end

    // Update walk: along the accessed way's path, point every node at the
    // other child so the accessed way becomes the least likely victim.
    always_comb begin
        tree_next = tree_bits;
        node_u    = '0;
        for (int lvl = 0; lvl < LEVELS; lvl++) begin
            tree_next[node_u] = ~access_way[LEVELS-1-lvl];
            node_u = LEVELS'((32'(node_u) << 1) + 32'd1 + 32'(access_way[LEVELS-1-lvl]));
        end
    end

endmodule

// File: rtl/dcache_nway.sv
// -----------------------------------------------------------------------------
// dcache_nway
// N-way set-associative, write-back, write-allocate data cache, one word per
// line, tree pseudo-LRU replacement, memory side through a req/ack handshake.
// Optional feature macro: CACHE_STATS_EN adds saturating hit/miss counters.
// Ports:
//   clk, reset (async, active-high)
//   cpu_req_valid/cpu_req_write/cpu_addr/cpu_wdata/cpu_byte_en : request
//   cpu_ready  : request accepted this cycle when high (IDLE only)
//   cpu_rvalid/cpu_rdata : load response, one-cycle pulse
//   mem_req/mem_we/mem_addr/mem_wdata : memory request (held until mem_ack)
//   mem_ack/mem_rdata : memory completion pulse and refill data
//   hit_count/miss_count : (CACHE_STATS_EN only) request statistics
// -----------------------------------------------------------------------------
module dcache_nway
    import dcache_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int SETS   = 8,
    parameter int WAYS   = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cpu_req_valid,
    input  logic                cpu_req_write,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic [DATA_W-1:0]   cpu_wdata,
    input  logic [DATA_W/8-1:0] cpu_byte_en,
    output logic                cpu_ready,
    output logic                cpu_rvalid,
    output logic [DATA_W-1:0]   cpu_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]         hit_count,
    output logic [31:0]         miss_count
`endif
);

    localparam int IDX_W  = idx_width(SETS);
    localparam int TAG_W  = tag_width(ADDR_W, SETS);
    localparam int PLRU_W = plru_width(WAYS);
    localparam int WAY_W  = way_width(WAYS);
    localparam int BYTES  = DATA_W / 8;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [TAG_W-1:0]  tag_arr  [WAYS][SETS];
    logic [DATA_W-1:0] data_arr [WAYS][SETS];
    line_state_t       meta_arr [WAYS][SETS];
    logic [PLRU_W-1:0] plru_arr [SETS];

    // ------------------------------------------------------------------
    // FSM and latched miss request
    // ------------------------------------------------------------------
    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   req_addr_reg;
    logic                req_write_reg;
    logic [DATA_W-1:0]   req_wdata_reg;
    logic [BYTES-1:0]    req_be_reg;
    logic [WAY_W-1:0]    victim_reg;

    logic [IDX_W-1:0]    cpu_idx;
    logic [TAG_W-1:0]    cpu_tag;
    logic [IDX_W-1:0]    req_idx;
    logic [IDX_W-1:0]    cur_idx;

    logic                accept;
    logic                ack;
    logic [WAYS-1:0]     hit_vec;
    logic                hit_any;
    logic [WAY_W-1:0]    hit_way;
    logic [DATA_W-1:0]   hit_data;
    logic                inv_found;
    logic [WAY_W-1:0]    inv_way;
    logic [WAY_W-1:0]    plru_victim;
    logic [WAY_W-1:0]    miss_victim;
    logic                victim_dirty;
    logic [WAY_W-1:0]    access_way;
    logic [PLRU_W-1:0]   plru_next;
    logic [DATA_W-1:0]   hit_merge;
    logic [DATA_W-1:0]   fill_merge;

    // Registered-output next values
    logic                cpu_ready_next;
    logic                cpu_rvalid_next;
    logic [DATA_W-1:0]   cpu_rdata_next;
    logic                mem_req_next;
    logic                mem_we_next;
    logic [ADDR_W-1:0]   mem_addr_next;
    logic [DATA_W-1:0]   mem_wdata_next;

    assign cpu_idx = cpu_addr[IDX_W-1:0];
    assign cpu_tag = cpu_addr[ADDR_W-1:IDX_W];
    assign req_idx = req_addr_reg[IDX_W-1:0];
    // Outside IDLE the tree of interest is the set of the latched miss.
    assign cur_idx = (state_reg == ST_IDLE) ? cpu_idx : req_idx;

    assign accept = cpu_req_valid && (state_reg == ST_IDLE);
    // A stray ack with no request outstanding must not advance anything.
    assign ack    = mem_ack && mem_req;

    // ------------------------------------------------------------------
    // Lookup
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < WAYS; gi++) begin : g_hit
            assign hit_vec[gi] = meta_arr[gi][cpu_idx].valid &&
                                 (tag_arr[gi][cpu_idx] == cpu_tag);
        end
    endgenerate

    assign hit_any  = |hit_vec;
    assign hit_data = data_arr[hit_way][cpu_idx];

    always_comb begin
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        // Descending loops leave the lowest matching index as the winner.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (hit_vec[w]) begin
                hit_way = WAY_W'(w);
            end
            if (!meta_arr[w][cpu_idx].valid) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
    end

    assign miss_victim  = inv_found ? inv_way : plru_victim;
    assign victim_dirty = meta_arr[miss_victim][cpu_idx].valid &&
                          meta_arr[miss_victim][cpu_idx].dirty;
    assign access_way   = (state_reg == ST_IDLE) ? hit_way : victim_reg;

    plru_tree #(
        .WAYS (WAYS)
    ) u_plru (
        .tree_bits  (plru_arr[cur_idx]),
        .access_way (access_way),
        .victim_way (plru_victim),
        .tree_next  (plru_next)
    );

    // Byte merges: store hit into the resident line, and latched store bytes
    // over the refill data.
    generate
        for (genvar gi = 0; gi < BYTES; gi++) begin : g_merge
            assign hit_merge[gi*8 +: 8]  = cpu_byte_en[gi] ? cpu_wdata[gi*8 +: 8]
                                                           : hit_data[gi*8 +: 8];
            assign fill_merge[gi*8 +: 8] = (req_write_reg && req_be_reg[gi])
                                           ? req_wdata_reg[gi*8 +: 8]
                                           : mem_rdata[gi*8 +: 8];
        end
    endgenerate

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept && !hit_any) begin
                    state_next = victim_dirty ? ST_WRITEBACK : ST_REFILL;
                end
            end
            ST_WRITEBACK: begin
                if (ack) begin
                    state_next = ST_REFILL;
                end
            end
            ST_REFILL: begin
                if (ack) begin
                    state_next = ST_RESPOND;
                end
            end
            ST_RESPOND: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs (next values, registered below)
    // ------------------------------------------------------------------
    always_comb begin
        cpu_ready_next  = (state_next == ST_IDLE);
        mem_req_next    = (state_next == ST_WRITEBACK) || (state_next == ST_REFILL);
        mem_we_next     = (state_next == ST_WRITEBACK);
        cpu_rvalid_next = 1'b0;
        cpu_rdata_next  = cpu_rdata;
        mem_addr_next   = mem_addr;
        mem_wdata_next  = mem_wdata;
        case (state_reg)
            ST_IDLE: begin
                if (accept && hit_any && !cpu_req_write) begin
                    cpu_rvalid_next = 1'b1;
                    cpu_rdata_next  = hit_data;
                end
                if (accept && !hit_any) begin
                    if (victim_dirty) begin
                        mem_addr_next  = {tag_arr[miss_victim][cpu_idx], cpu_idx};
                        mem_wdata_next = data_arr[miss_victim][cpu_idx];
                    end else begin
                        mem_addr_next  = cpu_addr;
                    end
                end
            end
            ST_WRITEBACK: begin
                if (ack) begin
                    mem_addr_next = req_addr_reg;
                end
            end
            ST_RESPOND: begin
                if (!req_write_reg) begin
                    cpu_rvalid_next = 1'b1;
                    cpu_rdata_next  = data_arr[victim_reg][req_idx];
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpu_ready  <= 1'b1;
            cpu_rvalid <= 1'b0;
            cpu_rdata  <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            cpu_ready  <= cpu_ready_next;
            cpu_rvalid <= cpu_rvalid_next;
            cpu_rdata  <= cpu_rdata_next;
            mem_req    <= mem_req_next;
            mem_we     <= mem_we_next;
            mem_addr   <= mem_addr_next;
            mem_wdata  <= mem_wdata_next;
        end
    end

    // ------------------------------------------------------------------
    // Tag/data arrays: no reset, validity is tracked in meta_arr.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (accept && hit_any && cpu_req_write) begin
            data_arr[hit_way][cpu_idx] <= hit_merge;
        end
        if ((state_reg == ST_REFILL) && ack) begin
            data_arr[victim_reg][req_idx] <= fill_merge;
            tag_arr[victim_reg][req_idx]  <= req_addr_reg[ADDR_W-1:IDX_W];
        end
    end

    // ------------------------------------------------------------------
    // Line status, PLRU trees, latched request, statistics
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int w = 0; w < WAYS; w++) begin
                for (int s = 0; s < SETS; s++) begin
                    meta_arr[w][s] <= '0;
                end
            end
            for (int s = 0; s < SETS; s++) begin
                plru_arr[s] <= '0;
            end
            req_addr_reg  <= '0;
            req_write_reg <= 1'b0;
            req_wdata_reg <= '0;
            req_be_reg    <= '0;
            victim_reg    <= '0;
`ifdef CACHE_STATS_EN
            hit_count     <= '0;
            miss_count    <= '0;
`endif
        end else begin
            if (accept) begin
                if (hit_any) begin
                    plru_arr[cpu_idx] <= plru_next;
                    if (cpu_req_write) begin
                        meta_arr[hit_way][cpu_idx].dirty <= 1'b1;
                    end
`ifdef CACHE_STATS_EN
                    if (hit_count != '1) begin
                        hit_count <= hit_count + 32'd1;
                    end
`endif
                end else begin
                    req_addr_reg  <= cpu_addr;
                    req_write_reg <= cpu_req_write;
                    req_wdata_reg <= cpu_wdata;
                    req_be_reg    <= cpu_byte_en;
                    victim_reg    <= miss_victim;
`ifdef CACHE_STATS_EN
                    if (miss_count != '1) begin
                        miss_count <= miss_count + 32'd1;
                    end
`endif
                end
            end
            if ((state_reg == ST_REFILL) && ack) begin
                meta_arr[victim_reg][req_idx].valid <= 1'b1;
                meta_arr[victim_reg][req_idx].dirty <= req_write_reg;
                plru_arr[req_idx]                   <= plru_next;
            end
        end
    end

endmodule

// File: tb/tb_dcache_nway.sv
// -----------------------------------------------------------------------------
// tb_dcache_nway
// Directed bench for dcache_nway (SETS=8, WAYS=2, 32-bit). A scoreboard queue
// holds expected load responses, another holds expected memory transactions;
// a memory responder and a response monitor pop and compare them.
// -----------------------------------------------------------------------------
module tb_dcache_nway;

    logic        clk;
    logic        reset;
    logic        cpu_req_valid;
    logic        cpu_req_write;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_byte_en;
    logic        cpu_ready;
    logic        cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
`ifdef CACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    dcache_nway #(
        .ADDR_W (32),
        .DATA_W (32),
        .SETS   (8),
        .WAYS   (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cpu_req_valid (cpu_req_valid),
        .cpu_req_write (cpu_req_write),
        .cpu_addr      (cpu_addr),
        .cpu_wdata     (cpu_wdata),
        .cpu_byte_en   (cpu_byte_en),
        .cpu_ready     (cpu_ready),
        .cpu_rvalid    (cpu_rvalid),
        .cpu_rdata     (cpu_rdata),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata)
`ifdef CACHE_STATS_EN
        ,
        .hit_count     (hit_count),
        .miss_count    (miss_count)
`endif
    );

    typedef struct {
        logic [31:0] data;
        bit          from_ack;
        int          exp_cyc;
    } rsp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mreq_t;

    rsp_t        sb[$];
    mreq_t       mq[$];
    logic [31:0] mm [256];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          last_ack_cyc = 0;
    bit          hold_ack = 0;
    bit          spurious = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Memory responder: acks each request two cycles after it is seen.
    initial begin
        int    wcnt;
        bit    prev_req;
        bit    prev_ack;
        bit    prev_wb_ack;
        logic [31:0] prev_addr;
        mreq_t e;
        wcnt = 0; prev_req = 0; prev_ack = 0; prev_wb_ack = 0; prev_addr = 0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (prev_wb_ack && !reset) begin
                chk("refill_follows_wb", 32'({mem_req, mem_we}), 32'h2);
            end
            if (mem_req && prev_req && !prev_ack && !reset) begin
                chk("mem_addr_stable", mem_addr, prev_addr);
            end
            prev_wb_ack = 0;
            prev_ack    = 0;
            if (mem_req && !hold_ack) begin
                wcnt++;
                if (wcnt >= 2) begin
                    wcnt = 0;
                    mem_ack = 1'b1;
                    prev_ack = 1;
                    last_ack_cyc = cyc;
                    $display("mem %s addr=0x%08h wdata=0x%08h rdata=0x%08h",
                             mem_we ? "wr" : "rd", mem_addr, mem_wdata, mm[mem_addr[7:0]]);
                    if (mq.size() == 0) begin
                        chk("mem_unexpected", 32'(mq.size()), 32'd1);
                    end else begin
                        e = mq.pop_front();
                        chk("mem_we", 32'(mem_we), 32'(e.we));
                        chk("mem_addr", mem_addr, e.addr);
                        if (e.we) begin
                            chk("mem_wdata", mem_wdata, e.wdata);
                        end
                    end
                    if (mem_we) begin
                        mm[mem_addr[7:0]] = mem_wdata;
                        prev_wb_ack = 1;
                    end else begin
                        mem_rdata = mm[mem_addr[7:0]];
                    end
                end
            end else begin
                wcnt = 0;
                if (!mem_req && spurious) begin
                    mem_ack  = 1'b1;
                    spurious = 0;
                end
            end
            prev_req  = mem_req;
            prev_addr = mem_addr;
        end
    end

    // Response monitor: every cpu_rvalid pops one expected response.
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            if (!reset && cpu_rvalid) begin
                $display("rsp cyc=%0d rdata=0x%08h", cyc, cpu_rdata);
                if (sb.size() == 0) begin
                    chk("rvalid_unexpected", 32'(sb.size()), 32'd1);
                end else begin
                    e = sb.pop_front();
                    chk("rdata", cpu_rdata, e.data);
                    chk("rvalid_latency", 32'(cyc),
                        e.from_ack ? 32'(last_ack_cyc + 2) : 32'(e.exp_cyc));
                end
            end
        end
    end

    task automatic exp_mem(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        mreq_t e;
        e.we = we; e.addr = addr; e.wdata = wdata;
        mq.push_back(e);
    endtask

    // kind: 0 = no response expected, 1 = load hit, 2 = load miss
    task automatic cpu_op(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input int kind, input logic [31:0] exp);
        int   n;
        rsp_t e;
        n = 0;
        while (!cpu_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before_req", 32'(cpu_ready), 32'd1);
        cpu_req_valid = 1'b1;
        cpu_req_write = wr;
        cpu_addr      = addr;
        cpu_wdata     = wdata;
        cpu_byte_en   = be;
        $display("req cyc=%0d %s addr=0x%08h wdata=0x%08h be=%b", cyc, wr ? "st" : "ld",
                 addr, wdata, be);
        if (kind != 0) begin
            e.data = exp; e.from_ack = (kind == 2); e.exp_cyc = cyc + 1;
            sb.push_back(e);
        end
        @(negedge clk);
        cpu_req_valid = 1'b0;
    endtask

    task automatic settle();
        int n;
        n = 0;
        while ((!cpu_ready || sb.size() != 0 || mq.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("settle_rsp_pending", 32'(sb.size()), 32'd0);
        chk("settle_mem_pending", 32'(mq.size()), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rsp_t e;
        for (int i = 0; i < 256; i++) mm[i] = 32'h0;
        mm[8'h10] = 32'hDEADBEEF;
        mm[8'h33] = 32'h12345678;
        reset = 1'b1;
        cpu_req_valid = 1'b0; cpu_req_write = 1'b0; cpu_addr = '0;
        cpu_wdata = '0; cpu_byte_en = '0;
        repeat (2) @(negedge clk);

        // Reset values
        chk("rst_cpu_ready", 32'(cpu_ready), 32'd1);
        chk("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        chk("rst_cpu_rdata", cpu_rdata, 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
`ifdef CACHE_STATS_EN
        chk("rst_hit_count", hit_count, 32'd0);
        chk("rst_miss_count", miss_count, 32'd0);
`endif
        reset = 1'b0;
        @(negedge clk);

        // Cold load 0x10
        exp_mem(1'b0, 32'h10, 32'h0);
        cpu_op(1'b0, 32'h10, 32'h0, 4'h0, 2, 32'hDEADBEEF);
        chk("miss_mem_req_next", 32'(mem_req), 32'd1);
        chk("miss_mem_we", 32'(mem_we), 32'd0);
        chk("miss_mem_addr", mem_addr, 32'h10);
        chk("miss_not_ready", 32'(cpu_ready), 32'd0);
        settle();

        // Repeat load hits
        cpu_op(1'b0, 32'h10, 32'h0, 4'h0, 1, 32'hDEADBEEF);
        chk("hit_no_mem_req", 32'(mem_req), 32'd0);
        chk("hit_stays_ready", 32'(cpu_ready), 32'd1);
        settle();

        // Stores 0x08 (clean miss), 0x10 (hit), 0x18 (dirty miss -> wb 0x08)
        exp_mem(1'b0, 32'h08, 32'h0);
        cpu_op(1'b1, 32'h08, 32'h11111111, 4'hF, 0, 32'h0);
        settle();
        cpu_op(1'b1, 32'h10, 32'h11111111, 4'hF, 0, 32'h0);
        chk("store_hit_no_mem_req", 32'(mem_req), 32'd0);
        settle();
        exp_mem(1'b1, 32'h08, 32'h11111111);
        exp_mem(1'b0, 32'h18, 32'h0);
        cpu_op(1'b1, 32'h18, 32'h11111111, 4'hF, 0, 32'h0);
        chk("wb_first_we", 32'(mem_we), 32'd1);
        settle();

        // Load 0x08: evicts dirty 0x10, refill returns written-back data
        exp_mem(1'b1, 32'h10, 32'h11111111);
        exp_mem(1'b0, 32'h08, 32'h0);
        cpu_op(1'b0, 32'h08, 32'h0, 4'h0, 2, 32'h11111111);
        settle();

        // Byte store into a line holding zero
        exp_mem(1'b0, 32'h21, 32'h0);
        cpu_op(1'b0, 32'h21, 32'h0, 4'h0, 2, 32'h0);
        settle();
        cpu_op(1'b1, 32'h21, 32'hAABBCCDD, 4'b0010, 0, 32'h0);
        settle();
        cpu_op(1'b0, 32'h21, 32'h0, 4'h0, 1, 32'h0000CC00);
        settle();

        // Stray mem_ack with no request outstanding
        spurious = 1;
        repeat (3) @(negedge clk);
        chk("stray_ack_ready", 32'(cpu_ready), 32'd1);
        chk("stray_ack_no_req", 32'(mem_req), 32'd0);

        // Back-to-back hits
        cpu_req_valid = 1'b1; cpu_req_write = 1'b0; cpu_addr = 32'h21; cpu_byte_en = 4'h0;
        e.data = 32'h0000CC00; e.from_ack = 0; e.exp_cyc = cyc + 1;
        sb.push_back(e);
        $display("req cyc=%0d ld addr=0x%08h (b2b)", cyc, cpu_addr);
        @(negedge clk);
        chk("b2b_ready", 32'(cpu_ready), 32'd1);
        cpu_addr = 32'h08;
        e.data = 32'h11111111; e.from_ack = 0; e.exp_cyc = cyc + 1;
        sb.push_back(e);
        $display("req cyc=%0d ld addr=0x%08h (b2b)", cyc, cpu_addr);
        @(negedge clk);
        cpu_req_valid = 1'b0;
        settle();

        // Reset during REFILL
        hold_ack = 1;
        cpu_op(1'b0, 32'h33, 32'h0, 4'h0, 0, 32'h0);
        chk("abort_mem_req_high", 32'(mem_req), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("abort_mem_req_async_drop", 32'(mem_req), 32'd0);
        chk("abort_ready", 32'(cpu_ready), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        hold_ack = 0;
        @(negedge clk);
`ifdef CACHE_STATS_EN
        chk("rst2_miss_count", miss_count, 32'd0);
`endif

        // After reset everything misses again
        exp_mem(1'b0, 32'h33, 32'h0);
        cpu_op(1'b0, 32'h33, 32'h0, 4'h0, 2, 32'h12345678);
        settle();
        exp_mem(1'b0, 32'h10, 32'h0);
        cpu_op(1'b0, 32'h10, 32'h0, 4'h0, 2, 32'h11111111);
        settle();
        exp_mem(1'b0, 32'h29, 32'h0);
        cpu_op(1'b0, 32'h29, 32'h0, 4'h0, 2, 32'h0);
        settle();
        cpu_op(1'b0, 32'h10, 32'h0, 4'h0, 1, 32'h11111111);
        settle();
        cpu_op(1'b0, 32'h33, 32'h0, 4'h0, 1, 32'h12345678);
        settle();
`ifdef CACHE_STATS_EN
        chk("stats_miss_count", miss_count, 32'd3);
        chk("stats_hit_count", hit_count, 32'd2);
`endif

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
